// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the 16-bit datapath: sequences each instruction
// over 3-5 cycles and drives registered datapath controls, PC enable and status.
module multicycle_control_unit #(
    parameter int unsigned RETIRE_W       = 16,
    parameter bit          START_ON_RESET = 1'b0
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                Run,
    input  logic [3:0]          opcode,
    output logic                RegDst,
    output logic                Branch,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                RegWrite,
    output logic                MemToReg,
    output logic                ALUSrc,
    output logic [1:0]          ALUOp,
    output logic                PCWrite,
    output logic                Halted,
    output logic                Illegal,
    output logic [2:0]          State,
    output logic [RETIRE_W-1:0] RetireCount
);

    localparam int unsigned STATE_W = 3;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned ALUOP_W = 2;

    localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] S_FETCH  = 3'd1;
    localparam logic [STATE_W-1:0] S_DECODE = 3'd2;
    localparam logic [STATE_W-1:0] S_EXEC   = 3'd3;
    localparam logic [STATE_W-1:0] S_MEM    = 3'd4;
    localparam logic [STATE_W-1:0] S_WB     = 3'd5;
    localparam logic [STATE_W-1:0] S_HALT   = 3'd7;

    localparam logic [OP_W-1:0] OP_RTYPE = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADDI  = 4'b0100;
    localparam logic [OP_W-1:0] OP_SLTI  = 4'b0101;
    localparam logic [OP_W-1:0] OP_LW    = 4'b1000;
    localparam logic [OP_W-1:0] OP_SW    = 4'b1100;
    localparam logic [OP_W-1:0] OP_BEQ   = 4'b0010;
    localparam logic [OP_W-1:0] OP_HALT  = 4'b1111;

    logic [STATE_W-1:0] state_q, state_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic               first_q;
    logic               done;

    logic               reg_dst_d, branch_d, mem_read_d, mem_write_d;
    logic               reg_write_d, mem_to_reg_d, alu_src_d;
    logic [ALUOP_W-1:0] alu_op_d;
    logic               pc_write_d, halted_d, illegal_d;

    function automatic logic is_legal(input logic [OP_W-1:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_SLTI, OP_LW,
            OP_SW, OP_BEQ, OP_HALT:              is_legal = 1'b1;
            default:                             is_legal = 1'b0;
        endcase
    endfunction

    assign State = state_q;

    // Next state plus the Moore outputs of that next state, so outputs register alongside it.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        done         = 1'b0;
        reg_dst_d    = 1'b0;
        branch_d     = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        alu_src_d    = 1'b0;
        alu_op_d     = '0;
        pc_write_d   = 1'b0;
        halted_d     = 1'b0;
        illegal_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Run || (START_ON_RESET && first_q)) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                op_d    = opcode;
                state_d = (opcode == OP_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                case (op_q)
                    OP_LW, OP_SW:               state_d = S_MEM;
                    OP_RTYPE, OP_ADDI, OP_SLTI: state_d = S_WB;
                    default:                    done    = 1'b1;
                endcase
            end
            S_MEM: begin
                if (op_q == OP_LW) state_d = S_WB;
                else               done    = 1'b1;
            end
            S_WB:    done    = 1'b1;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        // Run only matters at an instruction boundary.
        if (done) state_d = Run ? S_FETCH : S_IDLE;

        // Mux selects held from EXEC to the end of the instruction.
        if (state_d == S_EXEC || state_d == S_MEM || state_d == S_WB) begin
            case (op_d)
                OP_RTYPE: begin
                    reg_dst_d = 1'b1;
                    alu_op_d  = 2'b10;
                end
                OP_ADDI: alu_src_d = 1'b1;
                OP_SLTI: begin
                    alu_src_d = 1'b1;
                    alu_op_d  = 2'b11;
                end
                OP_LW: begin
                    alu_src_d    = 1'b1;
                    mem_to_reg_d = 1'b1;
                end
                OP_SW:   alu_src_d = 1'b1;
                OP_BEQ:  alu_op_d  = 2'b01;
                default: ;
            endcase
        end

        // Single-cycle strobes.
        case (state_d)
            S_EXEC: begin
                branch_d   = (op_d == OP_BEQ);
                illegal_d  = !is_legal(op_d);
                pc_write_d = (op_d == OP_BEQ) || !is_legal(op_d);
            end
            S_MEM: begin
                mem_read_d  = (op_d == OP_LW);
                mem_write_d = (op_d == OP_SW);
                pc_write_d  = (op_d == OP_SW);
            end
            S_WB: begin
                reg_write_d = 1'b1;
                pc_write_d  = 1'b1;
            end
            S_HALT:  halted_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            first_q     <= 1'b1;
            RegDst      <= 1'b0;
            Branch      <= 1'b0;
            MemRead     <= 1'b0;
            MemWrite    <= 1'b0;
            RegWrite    <= 1'b0;
            MemToReg    <= 1'b0;
            ALUSrc      <= 1'b0;
            ALUOp       <= '0;
            PCWrite     <= 1'b0;
            Halted      <= 1'b0;
            Illegal     <= 1'b0;
            RetireCount <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            first_q     <= 1'b0;
            RegDst      <= reg_dst_d;
            Branch      <= branch_d;
            MemRead     <= mem_read_d;
            MemWrite    <= mem_write_d;
            RegWrite    <= reg_write_d;
            MemToReg    <= mem_to_reg_d;
            ALUSrc      <= alu_src_d;
            ALUOp       <= alu_op_d;
            PCWrite     <= pc_write_d;
            Halted      <= halted_d;
            Illegal     <= illegal_d;
            // Counts the completion cycle once it has been presented on PCWrite.
            RetireCount <= RetireCount + RETIRE_W'(PCWrite);
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-state control vectors,
// latency, run/halt behaviour, start-on-reset and counter wrap.
module tb_multicycle_control_unit;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        Resetn, Run, Run2;
    logic [3:0]  opcode, opcode2;

    logic        RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc;
    logic [1:0]  ALUOp;
    logic        PCWrite, Halted, Illegal;
    logic [2:0]  State;
    logic [15:0] RetireCount;

    logic        reg_dst2, branch2, mem_read2, mem_write2, reg_write2, mem_to_reg2, alu_src2;
    logic [1:0]  alu_op2;
    logic        pc_write2, halted2, illegal2;
    logic [2:0]  state2;
    logic [3:0]  retire2;

    logic [11:0] ctrl, ctrl2;
    assign ctrl  = {RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc, ALUOp, PCWrite, Halted, Illegal};
    assign ctrl2 = {reg_dst2, branch2, mem_read2, mem_write2, reg_write2, mem_to_reg2, alu_src2, alu_op2, pc_write2, halted2, illegal2};

    // {RegDst,Branch,MemRead,MemWrite,RegWrite,MemToReg,ALUSrc,ALUOp[1:0],PCWrite,Halted,Illegal}
    localparam logic [11:0] C_ZERO    = 12'b0_0_0_0_0_0_0_00_0_0_0;
    localparam logic [11:0] C_R_EX    = 12'b1_0_0_0_0_0_0_10_0_0_0;
    localparam logic [11:0] C_R_WB    = 12'b1_0_0_0_1_0_0_10_1_0_0;
    localparam logic [11:0] C_ADDI_EX = 12'b0_0_0_0_0_0_1_00_0_0_0;
    localparam logic [11:0] C_ADDI_WB = 12'b0_0_0_0_1_0_1_00_1_0_0;
    localparam logic [11:0] C_SLTI_EX = 12'b0_0_0_0_0_0_1_11_0_0_0;
    localparam logic [11:0] C_SLTI_WB = 12'b0_0_0_0_1_0_1_11_1_0_0;
    localparam logic [11:0] C_LW_EX   = 12'b0_0_0_0_0_1_1_00_0_0_0;
    localparam logic [11:0] C_LW_MEM  = 12'b0_0_1_0_0_1_1_00_0_0_0;
    localparam logic [11:0] C_LW_WB   = 12'b0_0_0_0_1_1_1_00_1_0_0;
    localparam logic [11:0] C_SW_EX   = 12'b0_0_0_0_0_0_1_00_0_0_0;
    localparam logic [11:0] C_SW_MEM  = 12'b0_0_0_1_0_0_1_00_1_0_0;
    localparam logic [11:0] C_BEQ_EX  = 12'b0_1_0_0_0_0_0_01_1_0_0;
    localparam logic [11:0] C_ILL_EX  = 12'b0_0_0_0_0_0_0_00_1_0_1;
    localparam logic [11:0] C_HALT    = 12'b0_0_0_0_0_0_0_00_0_1_0;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_control_unit #(.RETIRE_W(16), .START_ON_RESET(1'b0)) dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .opcode(opcode),
        .RegDst(RegDst), .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .MemToReg(MemToReg), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
        .PCWrite(PCWrite), .Halted(Halted), .Illegal(Illegal), .State(State),
        .RetireCount(RetireCount)
    );

    multicycle_control_unit #(.RETIRE_W(4), .START_ON_RESET(1'b1)) dut2 (
        .Clock(Clock), .Resetn(Resetn), .Run(Run2), .opcode(opcode2),
        .RegDst(reg_dst2), .Branch(branch2), .MemRead(mem_read2), .MemWrite(mem_write2),
        .RegWrite(reg_write2), .MemToReg(mem_to_reg2), .ALUSrc(alu_src2), .ALUOp(alu_op2),
        .PCWrite(pc_write2), .Halted(halted2), .Illegal(illegal2), .State(state2),
        .RetireCount(retire2)
    );

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        step();
        step();
        Resetn = 1'b1;
    endtask

    task automatic test_reset();
        Run = 1'b1; opcode = 4'b0000;
        do_reset();
        n_cmp++; if (State !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", State); end
        n_cmp++; if (ctrl !== C_ZERO) begin n_err++; $display("FAIL reset_ctrl: got %b want %b", ctrl, C_ZERO); end
        n_cmp++; if (RetireCount !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", RetireCount); end
    endtask

    task automatic test_idle_wait();
        do_reset();
        Run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (State !== 3'd0 || ctrl !== C_ZERO) begin
                n_err++; $display("FAIL idle_wait k%0d: got state %0d ctrl %b want 0 %b", k, State, ctrl, C_ZERO);
            end
        end
    endtask

    task automatic test_rtype();
        logic [2:0]  st [4];
        logic [11:0] cv [4];
        st = '{3'd1, 3'd2, 3'd3, 3'd5};
        cv = '{C_ZERO, C_ZERO, C_R_EX, C_R_WB};
        do_reset();
        Run = 1'b1; opcode = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 4; k++) begin
                step();
                n_cmp++; if (State !== st[k]) begin n_err++; $display("FAIL rtype_state i%0d k%0d: got %0d want %0d", i, k, State, st[k]); end
                n_cmp++; if (ctrl !== cv[k]) begin n_err++; $display("FAIL rtype_ctrl i%0d k%0d: got %b want %b", i, k, ctrl, cv[k]); end
            end
        end
        step();
        n_cmp++; if (RetireCount !== 16'd3) begin n_err++; $display("FAIL rtype_count: got %0d want 3", RetireCount); end
    endtask

    task automatic test_lw();
        logic [2:0]  st [5];
        logic [11:0] cv [5];
        st = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        cv = '{C_ZERO, C_ZERO, C_LW_EX, C_LW_MEM, C_LW_WB};
        do_reset();
        Run = 1'b1; opcode = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++; if (State !== st[k]) begin n_err++; $display("FAIL lw_state k%0d: got %0d want %0d", k, State, st[k]); end
            n_cmp++; if (ctrl !== cv[k]) begin n_err++; $display("FAIL lw_ctrl k%0d: got %b want %b", k, ctrl, cv[k]); end
        end
        step();
        n_cmp++; if (State !== 3'd1 || RetireCount !== 16'd1) begin
            n_err++; $display("FAIL lw_after: got state %0d count %0d want 1 1", State, RetireCount);
        end
    endtask

    task automatic test_sw();
        logic [2:0]  st [4];
        logic [11:0] cv [4];
        st = '{3'd1, 3'd2, 3'd3, 3'd4};
        cv = '{C_ZERO, C_ZERO, C_SW_EX, C_SW_MEM};
        do_reset();
        Run = 1'b1; opcode = 4'b1100;
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++; if (State !== st[k]) begin n_err++; $display("FAIL sw_state k%0d: got %0d want %0d", k, State, st[k]); end
            n_cmp++; if (ctrl !== cv[k]) begin n_err++; $display("FAIL sw_ctrl k%0d: got %b want %b", k, ctrl, cv[k]); end
        end
        step();
        n_cmp++; if (State !== 3'd1 || RegWrite !== 1'b0 || RetireCount !== 16'd1) begin
            n_err++; $display("FAIL sw_after: got state %0d rw %b count %0d want 1 0 1", State, RegWrite, RetireCount);
        end
    endtask

    task automatic test_beq();
        logic [2:0]  st [3];
        logic [11:0] cv [3];
        st = '{3'd1, 3'd2, 3'd3};
        cv = '{C_ZERO, C_ZERO, C_BEQ_EX};
        do_reset();
        Run = 1'b1; opcode = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (State !== st[k]) begin n_err++; $display("FAIL beq_state k%0d: got %0d want %0d", k, State, st[k]); end
            n_cmp++; if (ctrl !== cv[k]) begin n_err++; $display("FAIL beq_ctrl k%0d: got %b want %b", k, ctrl, cv[k]); end
        end
        step();
        n_cmp++; if (State !== 3'd1 || RetireCount !== 16'd1) begin
            n_err++; $display("FAIL beq_after: got state %0d count %0d want 1 1", State, RetireCount);
        end
    endtask

    // ADDI then SLTI; the opcode input changes mid-instruction and must not leak through.
    task automatic test_back_to_back();
        logic [2:0]  st [8];
        logic [11:0] cv [8];
        st = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1, 3'd2, 3'd3, 3'd5};
        cv = '{C_ZERO, C_ZERO, C_ADDI_EX, C_ADDI_WB, C_ZERO, C_ZERO, C_SLTI_EX, C_SLTI_WB};
        do_reset();
        Run = 1'b1; opcode = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 2) opcode = 4'b0101;
            n_cmp++; if (State !== st[k]) begin n_err++; $display("FAIL b2b_state k%0d: got %0d want %0d", k, State, st[k]); end
            n_cmp++; if (ctrl !== cv[k]) begin n_err++; $display("FAIL b2b_ctrl k%0d: got %b want %b", k, ctrl, cv[k]); end
        end
        step();
        n_cmp++; if (RetireCount !== 16'd2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", RetireCount); end
    endtask

    task automatic test_illegal_halt();
        logic [2:0]  st [3];
        logic [11:0] cv [3];
        st = '{3'd1, 3'd2, 3'd3};
        cv = '{C_ZERO, C_ZERO, C_ILL_EX};
        do_reset();
        Run = 1'b1; opcode = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (State !== st[k]) begin n_err++; $display("FAIL ill_state k%0d: got %0d want %0d", k, State, st[k]); end
            n_cmp++; if (ctrl !== cv[k]) begin n_err++; $display("FAIL ill_ctrl k%0d: got %b want %b", k, ctrl, cv[k]); end
        end
        opcode = 4'b1111;
        step();
        n_cmp++; if (State !== 3'd1 || ctrl !== C_ZERO || RetireCount !== 16'd1) begin
            n_err++; $display("FAIL ill_after: got state %0d ctrl %b count %0d want 1 %b 1", State, ctrl, RetireCount, C_ZERO);
        end
        step();
        step();
        for (int j = 0; j < 4; j++) begin
            n_cmp++; if (State !== 3'd7 || ctrl !== C_HALT || RetireCount !== 16'd1) begin
                n_err++; $display("FAIL halt_hold j%0d: got state %0d ctrl %b count %0d want 7 %b 1", j, State, ctrl, RetireCount, C_HALT);
            end
            Run = j[0];
            step();
        end
        Resetn = 1'b0;
        step();
        Resetn = 1'b1;
        n_cmp++; if (State !== 3'd0 || ctrl !== C_ZERO || RetireCount !== 16'd0) begin
            n_err++; $display("FAIL halt_reset: got state %0d ctrl %b count %0d want 0 %b 0", State, ctrl, RetireCount, C_ZERO);
        end
    endtask

    task automatic test_run_drop();
        do_reset();
        Run = 1'b1; opcode = 4'b0000;
        step(); step(); step();
        n_cmp++; if (State !== 3'd3) begin n_err++; $display("FAIL drop_exec: got %0d want 3", State); end
        Run = 1'b0;
        step();
        n_cmp++; if (State !== 3'd5 || ctrl !== C_R_WB) begin
            n_err++; $display("FAIL drop_wb: got state %0d ctrl %b want 5 %b", State, ctrl, C_R_WB);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            n_cmp++; if (State !== 3'd0 || ctrl !== C_ZERO || RetireCount !== 16'd1) begin
                n_err++; $display("FAIL drop_idle k%0d: got state %0d ctrl %b count %0d want 0 %b 1", k, State, ctrl, RetireCount, C_ZERO);
            end
        end
    endtask

    task automatic test_start_and_wrap();
        Run = 1'b0; Run2 = 1'b0; opcode2 = 4'b0010;
        do_reset();
        step();
        n_cmp++; if (state2 !== 3'd1) begin n_err++; $display("FAIL start_fetch: got %0d want 1", state2); end
        step(); step();
        n_cmp++; if (state2 !== 3'd3 || ctrl2 !== C_BEQ_EX) begin
            n_err++; $display("FAIL start_exec: got state %0d ctrl %b want 3 %b", state2, ctrl2, C_BEQ_EX);
        end
        step();
        step();
        n_cmp++; if (state2 !== 3'd0 || retire2 !== 4'd1) begin
            n_err++; $display("FAIL start_idle: got state %0d count %0d want 0 1", state2, retire2);
        end
        Run2 = 1'b1;
        step();
        for (int m = 1; m <= 15; m++) begin
            step(); step(); step();
            if (m == 14) begin
                n_cmp++; if (retire2 !== 4'd15) begin n_err++; $display("FAIL wrap_pre: got %0d want 15", retire2); end
            end
        end
        n_cmp++; if (retire2 !== 4'd0 || state2 !== 3'd1) begin
            n_err++; $display("FAIL wrap: got count %0d state %0d want 0 1", retire2, state2);
        end
    endtask

    initial begin
        Resetn = 1'b0; Run = 1'b0; Run2 = 1'b0; opcode = 4'b0000; opcode2 = 4'b0010;
        test_reset();
        test_idle_wait();
        test_rtype();
        test_lw();
        test_sw();
        test_beq();
        test_back_to_back();
        test_illegal_halt();
        test_run_drop();
        test_start_and_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
